// File: rtl/counter_pkg.sv
// Shared types and default constants for the counter front-end.
package counter_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 500000;
  localparam int unsigned AUTO_DIV_DEFAULT = 50000000;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stable-count debounce filter.
// A new level is accepted only after N consecutive differing synced samples.
module debounce_filter
  import counter_pkg::*;
#(
  parameter int unsigned N         = DEBOUNCE_DEFAULT,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iRaw,
  output logic oStable
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= iRaw;
      sync2 <= sync1;
    end
  end

  // Any sample matching the accepted level restarts the count.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt     <= '0;
      oStable <= RESET_VAL;
    end else if (sync2 == oStable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(N - 1)) begin
      oStable <= sync2;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_input_conditioner.sv
// Conditions the step key and mode switches into clean, synchronous control
// for the skip/reverse counter: one-cycle step pulses plus stable mode levels.
module counter_input_conditioner
  import counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned AUTO_DIV        = AUTO_DIV_DEFAULT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iKeyStep_n,
  input  logic iSwSkip,
  input  logic iSwRev,
  input  logic iSwAuto,
  output logic oStep,
  output logic oSkip,
  output logic oRev,
  output logic oAuto
);

  localparam int unsigned PRE_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  logic key_db;
  logic skip_db;
  logic rev_db;
  logic auto_db;

  debounce_filter #(.N(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_key (
    .iClk(iClk), .iRst(iRst), .iRaw(iKeyStep_n), .oStable(key_db)
  );
  debounce_filter #(.N(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_skip (
    .iClk(iClk), .iRst(iRst), .iRaw(iSwSkip), .oStable(skip_db)
  );
  debounce_filter #(.N(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_rev (
    .iClk(iClk), .iRst(iRst), .iRaw(iSwRev), .oStable(rev_db)
  );
  debounce_filter #(.N(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_auto (
    .iClk(iClk), .iRst(iRst), .iRaw(iSwAuto), .oStable(auto_db)
  );

  key_state_e       state_q;
  key_state_e       state_d;
  logic             key_pulse;
  logic [PRE_W-1:0] presc;
  logic             presc_wrap;
  logic             step_d;

  // NOTE: defaults first so every path assigns every signal (no latch).
  always_comb begin
    state_d   = state_q;
    key_pulse = 1'b0;
    unique case (state_q)
      RELEASED: if (!key_db) begin
        state_d   = PRESSED;
        key_pulse = 1'b1;
      end
      PRESSED: if (key_db) state_d = RELEASED;
      default: state_d = RELEASED;
    endcase
  end

  // The key FSM keeps tracking in auto mode; only its pulse is ignored.
  assign presc_wrap = auto_db && (presc == PRE_W'(AUTO_DIV - 1));
  assign step_d     = (auto_db ? presc_wrap : key_pulse) && !oStep;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= RELEASED;
      presc   <= '0;
      oStep   <= 1'b0;
      oSkip   <= 1'b0;
      oRev    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!auto_db || presc_wrap) presc <= '0;
      else                        presc <= presc + 1'b1;
      oStep <= step_d;
      // Mode levels never change together with a step pulse.
      if (!step_d) begin
        oSkip <= skip_db;
        oRev  <= rev_db;
      end
    end
  end

  assign oAuto = auto_db;

endmodule

// File: doc/counter_input_conditioner.md
Name: counter_input_conditioner

Overview:
- Front-end stage directly upstream of the skip/reverse state counter.
- Turns raw board inputs into clean, clock-synchronous control for the counter:
  - one push-button (active-low, bouncy, asynchronous) becomes a single-cycle step pulse;
  - three slide switches (skip, reverse, auto) become debounced levels.
- An auto-run prescaler can generate step pulses periodically instead of the button.
- The counter advances only on cycles where oStep=1 (used as its clock enable); oSkip/oRev drive its iSkip/iRev.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a new input level (10 ms @ 50 MHz); must be >= 2.
- AUTO_DIV, 50000000, period of auto-mode step pulses in iClk cycles; must be >= 2.

Ports:
- iClk  in  1  system clock
- iRst  in  1  reset, synchronous, active-high
- iKeyStep_n  in  1  step push-button, active-low, asynchronous, bouncy
- iSwSkip  in  1  skip switch, asynchronous
- iSwRev  in  1  reverse switch, asynchronous
- iSwAuto  in  1  auto-run switch, asynchronous
- oStep  out  1  single-cycle step pulse (counter clock enable)
- oSkip  out  1  debounced skip level
- oRev  out  1  debounced reverse level
- oAuto  out  1  debounced auto level (status LED)

Behaviour:
- Reset (iRst=1 at a posedge):
  - oStep=0, oSkip=0, oRev=0, oAuto=0.
  - Key synchroniser and key stable value = 1 (released); switch synchronisers and stable values = 0.
  - All debounce counters = 0; prescaler = 0; key FSM = RELEASED.
  - Reset mid-debounce or mid-prescale discards all progress.
- Synchronisation: every asynchronous input passes through a 2-flop synchroniser; only the second flop is used.
- Debounce filter, per input:
  - If the synced sample equals the stable value, cnt<=0.
  - Otherwise cnt increments.
  - When cnt==DEBOUNCE_CYCLES-1 and the sample still differs: stable<=sample, cnt<=0.
  - Any sample equal to stable before that point restarts the count.
  - Result: the pin change is accepted at posedge DEBOUNCE_CYCLES+2, counting the first posedge at which the pin is at its new level as posedge 1.
- Key FSM (states RELEASED, PRESSED):
  - RELEASED -> PRESSED when the debounced key goes 0; in that transition oStep<=1 for exactly one cycle, visible after posedge DEBOUNCE_CYCLES+3.
  - PRESSED -> RELEASED when the debounced key goes 1; no pulse.
  - Holding the key gives exactly one pulse. A new press is recognised only after a debounced release.
- Auto mode:
  - While oAuto=1, the prescaler counts 0..AUTO_DIV-1 and wraps; oStep<=1 in the cycle after the prescaler reaches AUTO_DIV-1.
  - The first pulse comes AUTO_DIV cycles after oAuto rises.
  - Key-generated pulses are suppressed; the key FSM still tracks the key, so no stale pulse is emitted on exit.
  - While oAuto=0, the prescaler is held at 0.
- oStep is registered, never high for two consecutive cycles, and at most one source drives it per cycle.
- oSkip/oRev:
  - Take the debounced switch values.
  - An update that would land in a cycle where oStep=1 is deferred by one cycle, so mode inputs are stable across every step pulse.
- oAuto follows the debounced switch directly.
- Widths:
  - Debounce counter = $clog2(DEBOUNCE_CYCLES); prescaler = $clog2(AUTO_DIV).
  - Compare with ==; overflow never occurs.

Decomposition:
- Shared package counter_pkg:
  - key FSM state encoding (RELEASED=1'b0, PRESSED=1'b1);
  - default constants DEBOUNCE_DEFAULT=500000 and AUTO_DIV_DEFAULT=50000000.
- One sub-module: debounce_filter.
  - Parameters: N, RESET_VAL.
  - Ports: iClk, iRst, iRaw, oStable.
  - Contains the 2-flop synchroniser and the filter counter.
  - Instantiated four times (key, skip, rev, auto).
- Key FSM, prescaler and output registers live in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES=4, AUTO_DIV=8; posedges counted from the first posedge with the pin at its new level):
- Reset with key held low for 3 cycles -> all outputs 0 and no pulse during reset; after iRst falls with the key still low, exactly one oStep, high after posedge 7.
- Clean press held low 20 cycles -> one oStep, high after posedge 7 only; release then press again -> second single pulse, same latency.
- Bounce: key low 3 cycles, high 1, low 10 -> exactly one oStep, 7 posedges after the start of the final low period; release bounce of 2-cycle glitches -> no extra pulse.
- Auto: iSwAuto=1 (oAuto=1 after posedge 6) -> oStep every 8 cycles, first one 8 cycles after oAuto rises; key presses meanwhile produce no pulses; iSwAuto=0 -> pulses stop, and re-enabling gives first pulse 8 cycles later again.
- Switch/step coincidence: time the iSwRev debounced change to land on an oStep cycle -> oRev rises one cycle after the pulse, not with it.
- Reset asserted mid-debounce (key low 2 cycles) -> no pulse; the counter restarts from 0 after reset.
